// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the pixel clock.
// Emits registered syncs, display enable, raw coordinates and line/frame strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          resync,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_L  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_L  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic          VS_ON    = (VS_POL != 0) ? 1'b1 : 1'b0;

  logic [CW-1:0] r_hc;
  logic [CW-1:0] r_vc;
  logic [CW-1:0] w_src_hc;
  logic [CW-1:0] w_src_vc;
  logic [CW-1:0] w_hc_nxt;
  logic [CW-1:0] w_vc_nxt;
  logic          w_de;
  logic          w_hs;
  logic          w_vs;
  logic          w_ls;
  logic          w_fs;

  // Decode source is the live count, or pixel (0,0) when a resync is requested.
  always_comb begin
    w_src_hc = r_hc;
    w_src_vc = r_vc;
    if (resync) begin
      w_src_hc = '0;
      w_src_vc = '0;
    end else begin
      w_src_hc = r_hc;
      w_src_vc = r_vc;
    end
    w_de = (w_src_hc < H_ACT_L) && (w_src_vc < V_ACT_L);
    w_hs = ((w_src_hc >= H_SYNC_S) && (w_src_hc < H_SYNC_E)) ? HS_ON : ~HS_ON;
    w_vs = ((w_src_vc >= V_SYNC_S) && (w_src_vc < V_SYNC_E)) ? VS_ON : ~VS_ON;
    w_ls = (w_src_hc == '0);
    w_fs = (w_src_hc == '0) && (w_src_vc == '0);
  end

  // Raster step: vc advances only when hc wraps.
  always_comb begin
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (r_hc == H_LAST) begin
      w_hc_nxt = '0;
      if (r_vc == V_LAST) begin
        w_vc_nxt = '0;
      end else begin
        w_vc_nxt = r_vc + CW'(1);
      end
    end else begin
      w_hc_nxt = r_hc + CW'(1);
      w_vc_nxt = r_vc;
    end
  end

  // Counter and output registers; reset beats resync, resync beats the pause.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      r_hc        <= '0;
      r_vc        <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_sync      <= ~HS_ON;
      v_sync      <= ~VS_ON;
    end else if (resync || enable) begin
      // On resync the decode already shows (0,0), so the counters skip ahead to hc=1.
      r_hc        <= resync ? CW'(1) : w_hc_nxt;
      r_vc        <= resync ? '0 : w_vc_nxt;
      x           <= w_src_hc;
      y           <= w_src_vc;
      de          <= w_de;
      line_start  <= w_ls;
      frame_start <= w_fs;
      h_sync      <= w_hs;
      v_sync      <= w_vs;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: vector table on a tiny raster, plus multi-cycle sequences on both rasters.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default 640x480 instance
  logic        d_reset, d_en, d_rs;
  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x, d_y;

  // Tiny instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-high syncs
  logic        s_reset, s_en, s_rs;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [3:0]  s_x, s_y;

  vga_timing_gen u_def (
    .pixel_clk(clk), .reset(d_reset), .enable(d_en), .resync(d_rs),
    .h_sync(d_hs), .v_sync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(4)
  ) u_small (
    .pixel_clk(clk), .reset(s_reset), .enable(s_en), .resync(s_rs),
    .h_sync(s_hs), .v_sync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  typedef struct {
    logic       rst, en, rs;
    logic [3:0] x, y;
    logic       de, hs, vs, ls, fs;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;
  int k, period, de_n, hs_n, vs_n, ls_n, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, en, rs, input int xx, yy,
                              input logic de, hs, vs, ls, fs);
    vec_t v;
    v.rst = rst; v.en = en; v.rs = rs;
    v.x = 4'(xx); v.y = 4'(yy);
    v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  initial begin
    //            rst   en    rs    x  y  de    hs    vs    ls    fs
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[21] = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[22] = mk(1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[23] = mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[24] = mk(1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    d_reset = 1'b0; d_en = 1'b1; d_rs = 1'b0;
    s_reset = 1'b0; s_en = 1'b1; s_rs = 1'b0;
    #2;

    // Tiny raster: per-edge vector table
    for (int i = 0; i < NV; i++) begin
      s_reset = tbl[i].rst; s_en = tbl[i].en; s_rs = tbl[i].rs;
      tick();
      chk($sformatf("v%0d.x", i),  32'(s_x),  32'(tbl[i].x));
      chk($sformatf("v%0d.y", i),  32'(s_y),  32'(tbl[i].y));
      chk($sformatf("v%0d.de", i), 32'(s_de), 32'(tbl[i].de));
      chk($sformatf("v%0d.hs", i), 32'(s_hs), 32'(tbl[i].hs));
      chk($sformatf("v%0d.vs", i), 32'(s_vs), 32'(tbl[i].vs));
      chk($sformatf("v%0d.ls", i), 32'(s_ls), 32'(tbl[i].ls));
      chk($sformatf("v%0d.fs", i), 32'(s_fs), 32'(tbl[i].fs));
    end

    // Tiny raster: one full frame between frame_start strobes
    s_reset = 1'b1; s_en = 1'b1; s_rs = 1'b0;
    k = 0;
    do begin tick(); k++; end while (s_fs !== 1'b1 && k < 100);
    chk("s.fs_found", 32'(s_fs), 32'd1);
    period = 0; de_n = 0; hs_n = 0; vs_n = 0; bad = 0;
    do begin
      if (s_de) begin de_n++; if (!(s_x < 4'd4 && s_y < 4'd3)) bad++; end
      if (s_hs) begin hs_n++; if (s_x < 4'd5 || s_x > 4'd6) bad++; end
      if (s_vs) begin vs_n++; if (s_y != 4'd4) bad++; end
      tick(); period++;
    end while (s_fs !== 1'b1 && period < 200);
    chk("s.frame_period", 32'(period), 32'd48);
    chk("s.de_count", 32'(de_n), 32'd12);
    chk("s.hs_count", 32'(hs_n), 32'd12);
    chk("s.vs_count", 32'(vs_n), 32'd8);
    chk("s.decode_pos", 32'(bad), 32'd0);

    // Default raster: reset held for three edges
    d_reset = 1'b0; d_en = 1'b1; d_rs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d.rst_hs", 32'(d_hs), 32'd1);
      chk("d.rst_vs", 32'(d_vs), 32'd1);
      chk("d.rst_de", 32'(d_de), 32'd0);
    end
    d_reset = 1'b1;
    tick();
    chk("d.first_de", 32'(d_de), 32'd1);
    chk("d.first_x",  32'(d_x),  32'd0);
    chk("d.first_y",  32'(d_y),  32'd0);
    chk("d.first_ls", 32'(d_ls), 32'd1);
    chk("d.first_fs", 32'(d_fs), 32'd1);

    // Default raster: one line
    de_n = 1; hs_n = 0; ls_n = 0; bad = 0;
    for (int i = 1; i < 800; i++) begin
      tick();
      if (d_de) de_n++;
      if (!d_hs) begin hs_n++; if (d_x < 11'd656 || d_x > 11'd751) bad++; end
      if (d_ls) ls_n++;
    end
    chk("d.line_last_x", 32'(d_x), 32'd799);
    chk("d.line_de", 32'(de_n), 32'd640);
    chk("d.line_hs", 32'(hs_n), 32'd96);
    chk("d.hs_pos", 32'(bad), 32'd0);
    chk("d.ls_none", 32'(ls_n), 32'd0);
    tick();
    chk("d.wrap_x", 32'(d_x), 32'd0);
    chk("d.wrap_y", 32'(d_y), 32'd1);
    chk("d.wrap_ls", 32'(d_ls), 32'd1);
    chk("d.wrap_fs", 32'(d_fs), 32'd0);

    // Default raster: pause at x=100
    k = 0;
    while (d_x !== 11'd100 && k < 1000) begin tick(); k++; end
    chk("d.reach100", 32'(d_x), 32'd100);
    d_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("d.hold_x",  32'(d_x),  32'd100);
      chk("d.hold_y",  32'(d_y),  32'd1);
      chk("d.hold_de", 32'(d_de), 32'd1);
      chk("d.hold_hs", 32'(d_hs), 32'd1);
      chk("d.hold_vs", 32'(d_vs), 32'd1);
    end
    d_en = 1'b1;
    tick();
    chk("d.resume_x", 32'(d_x), 32'd101);

    // Default raster: resync at x=300, with enable high then low
    for (int pass = 0; pass < 2; pass++) begin
      k = 0;
      while (d_x !== 11'd300 && k < 1000) begin tick(); k++; end
      chk("d.reach300", 32'(d_x), 32'd300);
      d_rs = 1'b1; d_en = (pass == 0) ? 1'b1 : 1'b0;
      tick();
      chk("d.rs_x",  32'(d_x),  32'd0);
      chk("d.rs_y",  32'(d_y),  32'd0);
      chk("d.rs_fs", 32'(d_fs), 32'd1);
      chk("d.rs_de", 32'(d_de), 32'd1);
      d_rs = 1'b0; d_en = 1'b1;
      tick();
      chk("d.rs_next_x", 32'(d_x), 32'd1);
      chk("d.rs_next_fs", 32'(d_fs), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
